// File: rtl/tag_ctrl_pkg.sv
// Shared types and default widths for the tag array controller and its victim selector.
package tag_ctrl_pkg;

  localparam int SET_W_DEF = 3;
  localparam int TAG_W_DEF = 24;
  localparam int WAYS_DEF  = 4;

  typedef enum logic {INIT, RUN} tag_ctrl_state_e;

  typedef struct packed {
    logic                 vld;
    logic [TAG_W_DEF-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/tag_ctrl_victim_sel.sv
// Replacement choice: lowest-index invalid way, otherwise a round-robin pointer
// that advances only on misses where every way was valid.
module tag_victim_sel
  import tag_ctrl_pkg::*;
#(
  parameter int WAYS = WAYS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WAYS-1:0] way_vld,
  input  logic            advance,
  output logic [WAYS-1:0] victim
);

  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [WAYS-1:0]  inv;

  always_comb begin
    inv = ~way_vld;
    if (|inv) begin
      victim = inv & (~inv + WAYS'(1));
    end else begin
      victim = WAYS'(1) << rr_ptr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (rr_ptr == PTR_W'(WAYS - 1)) ? '0 : rr_ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/tag_ctrl.sv
// Tag SRAM controller: post-reset clear sweep (TAG_CTRL_INIT_EN), lookup/update
// arbitration with update priority and a starvation guard, one-cycle hit/victim report.
module tag_ctrl
  import tag_ctrl_pkg::*;
#(
  parameter int SET_W          = SET_W_DEF,
  parameter int TAG_W          = TAG_W_DEF,
  parameter int WAYS           = WAYS_DEF,
  parameter int MAX_UPD_STREAK = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         init_done,
  input  logic                         lk_valid,
  output logic                         lk_ready,
  input  logic [SET_W-1:0]             lk_set,
  input  logic [TAG_W-1:0]             lk_tag,
  output logic                         lk_rsp_valid,
  output logic                         lk_rsp_hit,
  output logic [WAYS-1:0]              lk_rsp_way,
  output logic [WAYS-1:0]              lk_rsp_victim,
  input  logic                         upd_valid,
  output logic                         upd_ready,
  input  logic [SET_W-1:0]             upd_set,
  input  logic [WAYS-1:0]              upd_way_en,
  input  logic [TAG_W-1:0]             upd_tag,
  input  logic                         upd_vld,
  output logic                         arr_rd_valid,
  input  logic                         arr_rd_ready,
  output logic [SET_W-1:0]             arr_rd_set,
  input  logic [WAYS*(TAG_W+1)-1:0]    arr_rd_rsp,
  output logic                         arr_wr_valid,
  input  logic                         arr_wr_ready,
  output logic [SET_W-1:0]             arr_wr_set,
  output logic [WAYS-1:0]              arr_wr_way_en,
  output logic [TAG_W:0]               arr_wr_data
);

  localparam int ENTRY_W  = TAG_W + 1;
  localparam int STREAK_W = $clog2(MAX_UPD_STREAK + 1);

`ifdef TAG_CTRL_INIT_EN
  localparam tag_ctrl_state_e RESET_STATE = INIT;
`else
  localparam tag_ctrl_state_e RESET_STATE = RUN;
`endif

  tag_ctrl_state_e       state, state_nxt;
  logic [SET_W-1:0]      init_set;
  logic [STREAK_W-1:0]   streak;
  logic                  starve;
  logic                  upd_grant;
  logic                  lk_grant;
  logic                  vld_p1;
  logic [TAG_W-1:0]      tag_p1;
  logic [WAYS-1:0]       way_vld;
  logic [WAYS-1:0]       match;
  logic [WAYS-1:0]       hit_onehot;
  logic [WAYS-1:0]       victim;
  logic                  any_hit;
  logic                  advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RESET_STATE;
      init_set <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT && arr_wr_ready) begin
        init_set <= init_set + SET_W'(1);
      end
    end
  end

  assign starve = (streak == STREAK_W'(MAX_UPD_STREAK));

  always_comb begin
    state_nxt     = state;
    init_done     = 1'b0;
    lk_ready      = 1'b0;
    upd_ready     = 1'b0;
    arr_rd_valid  = 1'b0;
    arr_rd_set    = lk_set;
    arr_wr_valid  = 1'b0;
    arr_wr_set    = upd_set;
    arr_wr_way_en = upd_way_en;
    arr_wr_data   = {upd_vld, upd_tag};
    case (state)
      INIT: begin
        arr_wr_valid  = !rst;
        arr_wr_set    = init_set;
        arr_wr_way_en = '1;
        arr_wr_data   = '0;
        if (arr_wr_ready && (&init_set)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        init_done    = 1'b1;
        upd_ready    = !rst && arr_wr_ready && !starve;
        arr_wr_valid = !rst && upd_valid && !starve;
        arr_rd_valid = !rst && lk_valid && !(upd_valid && upd_ready);
        lk_ready     = !rst && arr_rd_ready && !(upd_valid && upd_ready);
      end
      default: state_nxt = RESET_STATE;
    endcase
  end

  assign upd_grant = upd_valid && upd_ready;
  assign lk_grant  = lk_valid && lk_ready;

  // A waiting lookup forgives updates only MAX_UPD_STREAK times in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (lk_grant || !lk_valid) begin
      streak <= '0;
    end else if (upd_grant) begin
      streak <= streak + STREAK_W'(1);
    end
  end

  // p0 -> p1: lookup accepted, array read in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= lk_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (lk_grant) begin
      tag_p1 <= lk_tag;
    end
  end

  // p1: compare returned ways against the registered tag
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      way_vld[w] = arr_rd_rsp[w*ENTRY_W + TAG_W];
      match[w]   = way_vld[w] && (arr_rd_rsp[w*ENTRY_W +: TAG_W] == tag_p1);
    end
  end

  assign hit_onehot = match & (~match + WAYS'(1));
  assign any_hit    = |match;
  assign advance    = vld_p1 && !any_hit && (&way_vld);

  tag_victim_sel #(
    .WAYS(WAYS)
  ) u_victim (
    .clk     (clk),
    .rst     (rst),
    .way_vld (way_vld),
    .advance (advance),
    .victim  (victim)
  );

  assign lk_rsp_valid  = vld_p1;
  assign lk_rsp_hit    = vld_p1 && any_hit;
  assign lk_rsp_way    = vld_p1 ? hit_onehot : '0;
  assign lk_rsp_victim = (vld_p1 && !any_hit) ? victim : '0;

endmodule

// File: tb/tb_tag_ctrl.sv
// Bench for tag_ctrl: SRAM model, behavioural cache/arbiter model checked every cycle,
// directed cases with literal expectations, then randomized traffic with a mid-run reset.
`timescale 1ns/1ps
module tb_tag_ctrl;

  localparam int SET_W          = 3;
  localparam int TAG_W          = 24;
  localparam int WAYS           = 4;
  localparam int MAX_UPD_STREAK = 4;
  localparam int SETS           = 1 << SET_W;
  localparam int ENTRY_W        = TAG_W + 1;
`ifdef TAG_CTRL_INIT_EN
  localparam int INIT_CYC = 9;
`else
  localparam int INIT_CYC = 1;
`endif

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      init_done;
  logic                      lk_valid, lk_ready;
  logic [SET_W-1:0]          lk_set;
  logic [TAG_W-1:0]          lk_tag;
  logic                      lk_rsp_valid, lk_rsp_hit;
  logic [WAYS-1:0]           lk_rsp_way, lk_rsp_victim;
  logic                      upd_valid, upd_ready;
  logic [SET_W-1:0]          upd_set;
  logic [WAYS-1:0]           upd_way_en;
  logic [TAG_W-1:0]          upd_tag;
  logic                      upd_vld;
  logic                      arr_rd_valid, arr_rd_ready;
  logic [SET_W-1:0]          arr_rd_set;
  logic [WAYS*ENTRY_W-1:0]   arr_rd_rsp;
  logic                      arr_wr_valid, arr_wr_ready;
  logic [SET_W-1:0]          arr_wr_set;
  logic [WAYS-1:0]           arr_wr_way_en;
  logic [ENTRY_W-1:0]        arr_wr_data;

  tag_ctrl #(
    .SET_W(SET_W), .TAG_W(TAG_W), .WAYS(WAYS), .MAX_UPD_STREAK(MAX_UPD_STREAK)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_set(lk_set), .lk_tag(lk_tag),
    .lk_rsp_valid(lk_rsp_valid), .lk_rsp_hit(lk_rsp_hit), .lk_rsp_way(lk_rsp_way),
    .lk_rsp_victim(lk_rsp_victim),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_set(upd_set),
    .upd_way_en(upd_way_en), .upd_tag(upd_tag), .upd_vld(upd_vld),
    .arr_rd_valid(arr_rd_valid), .arr_rd_ready(arr_rd_ready), .arr_rd_set(arr_rd_set),
    .arr_rd_rsp(arr_rd_rsp),
    .arr_wr_valid(arr_wr_valid), .arr_wr_ready(arr_wr_ready), .arr_wr_set(arr_wr_set),
    .arr_wr_way_en(arr_wr_way_en), .arr_wr_data(arr_wr_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM: requests are latched mid-cycle, applied at the clock edge; reads see pre-write data.
  logic [ENTRY_W-1:0] sram [SETS][WAYS];
  logic               rd_q, wr_q;
  logic [SET_W-1:0]   rd_set_q, wr_set_q;
  logic [WAYS-1:0]    wr_en_q;
  logic [ENTRY_W-1:0] wr_data_q;

  always @(negedge clk) begin
    rd_q      = arr_rd_valid && arr_rd_ready;
    rd_set_q  = arr_rd_set;
    wr_q      = arr_wr_valid && arr_wr_ready;
    wr_set_q  = arr_wr_set;
    wr_en_q   = arr_wr_way_en;
    wr_data_q = arr_wr_data;
  end

  always @(posedge clk) begin
    if (rd_q && !rst)
      for (int w = 0; w < WAYS; w++) arr_rd_rsp[w*ENTRY_W +: ENTRY_W] <= sram[rd_set_q][w];
    if (wr_q && !rst)
      for (int w = 0; w < WAYS; w++) if (wr_en_q[w]) sram[wr_set_q][w] <= wr_data_q;
  end

  // Behavioural model: cache contents, round-robin index, update streak, init progress.
  logic            ref_vld [SETS][WAYS];
  logic [TAG_W-1:0] ref_tag [SETS][WAYS];
  int              ref_rr   = 0;
  int              upd_run  = 0;
  int              init_cnt = 0;
  bit              done_m   = 1'b0;
  logic            exp_rsp  = 1'b0;
  logic            exp_hit;
  logic [WAYS-1:0] exp_way, exp_vic;
  logic            m_ug, m_lg, m_eur;

  task automatic model_lookup(input int s, input logic [TAG_W-1:0] t);
    int inv;
    inv     = -1;
    exp_hit = 1'b0;
    exp_way = '0;
    exp_vic = '0;
    for (int w = 0; w < WAYS; w++)
      if (!exp_hit && ref_vld[s][w] && ref_tag[s][w] == t) begin
        exp_hit    = 1'b1;
        exp_way[w] = 1'b1;
      end
    if (!exp_hit) begin
      for (int w = 0; w < WAYS; w++) if (inv < 0 && !ref_vld[s][w]) inv = w;
      if (inv >= 0) exp_vic[inv] = 1'b1;
      else begin
        exp_vic[ref_rr] = 1'b1;
        ref_rr = (ref_rr + 1) % WAYS;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("rst_lk_ready", lk_ready, 0);
      check("rst_upd_ready", upd_ready, 0);
      check("rst_arr_rd_valid", arr_rd_valid, 0);
      check("rst_arr_wr_valid", arr_wr_valid, 0);
      check("rst_lk_rsp_valid", lk_rsp_valid, 0);
`ifdef TAG_CTRL_INIT_EN
      check("rst_init_done", init_done, 0);
      for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) ref_vld[s][w] = 1'b0;
      done_m = 1'b0;
`else
      done_m = 1'b1;
`endif
      exp_rsp  = 1'b0;
      ref_rr   = 0;
      upd_run  = 0;
      init_cnt = 0;
    end else begin
      check("rsp_valid", lk_rsp_valid, exp_rsp);
      if (exp_rsp) begin
        check("rsp_hit", lk_rsp_hit, exp_hit);
        check("rsp_way", lk_rsp_way, exp_way);
        check("rsp_victim", lk_rsp_victim, exp_vic);
      end
      check("init_done", init_done, done_m);
      if (!done_m) begin
        check("init_wr_valid", arr_wr_valid, 1);
        check("init_wr_set", arr_wr_set, init_cnt);
        check("init_wr_way_en", arr_wr_way_en, 4'hF);
        check("init_wr_data", arr_wr_data, 0);
        check("init_lk_ready", lk_ready, 0);
        check("init_upd_ready", upd_ready, 0);
        exp_rsp = 1'b0;
        if (arr_wr_ready) init_cnt++;
        if (init_cnt == SETS) done_m = 1'b1;
      end else begin
        m_eur = arr_wr_ready && (upd_run < MAX_UPD_STREAK);
        m_ug  = upd_valid && m_eur;
        m_lg  = lk_valid && arr_rd_ready && !m_ug;
        check("upd_ready", upd_ready, m_eur);
        check("lk_ready", lk_ready, arr_rd_ready && !m_ug);
        check("arr_rd_valid", arr_rd_valid, lk_valid && !m_ug);
        check("arr_wr_valid", arr_wr_valid, upd_valid && (upd_run < MAX_UPD_STREAK));
        if (lk_valid && !m_ug) check("arr_rd_set", arr_rd_set, lk_set);
        if (upd_valid && (upd_run < MAX_UPD_STREAK)) begin
          check("arr_wr_set", arr_wr_set, upd_set);
          check("arr_wr_way_en", arr_wr_way_en, upd_way_en);
          check("arr_wr_data", arr_wr_data, {upd_vld, upd_tag});
        end
        exp_rsp = m_lg;
        if (m_lg) model_lookup(lk_set, lk_tag);
        if (m_ug)
          for (int w = 0; w < WAYS; w++)
            if (upd_way_en[w]) begin
              ref_vld[upd_set][w] = upd_vld;
              ref_tag[upd_set][w] = upd_tag;
            end
        if (m_lg || !lk_valid) upd_run = 0;
        else if (m_ug) upd_run++;
      end
    end
  end

  // Directed helpers: start and end just after a rising edge.
  task automatic do_update(input logic [SET_W-1:0] s, input logic [WAYS-1:0] we,
                           input logic [TAG_W-1:0] t, input logic v);
    logic got;
    got = 1'b0;
    upd_valid = 1'b1; upd_set = s; upd_way_en = we; upd_tag = t; upd_vld = v;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = upd_ready;
    end
    @(posedge clk); #1;
    upd_valid = 1'b0;
    check("upd_grant_timeout", got, 1);
  endtask

  task automatic do_lookup(input logic [SET_W-1:0] s, input logic [TAG_W-1:0] t,
                           output logic hit, output logic [WAYS-1:0] way,
                           output logic [WAYS-1:0] vic);
    logic got;
    got = 1'b0;
    lk_valid = 1'b1; lk_set = s; lk_tag = t;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = lk_ready;
    end
    @(posedge clk); #1;
    lk_valid = 1'b0;
    @(negedge clk);
    check("lk_grant_timeout", got, 1);
    check("dir_rsp_valid", lk_rsp_valid, 1);
    hit = lk_rsp_hit; way = lk_rsp_way; vic = lk_rsp_victim;
    @(posedge clk); #1;
  endtask

  task automatic wait_init(input string name);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
`ifdef TAG_CTRL_INIT_EN
      if (cyc == 1) check({name, "_first_set"}, arr_wr_set, 0);
`endif
    end while (!init_done && cyc < 40);
    check({name, "_cycles"}, cyc, INIT_CYC);
    @(posedge clk); #1;
  endtask

  logic            d_hit;
  logic [WAYS-1:0] d_way, d_vic;
  logic [WAYS-1:0] vic_tab [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vic_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b1;
    lk_valid = 1'b0; lk_set = '0; lk_tag = '0;
    upd_valid = 1'b0; upd_set = '0; upd_way_en = '0; upd_tag = '0; upd_vld = 1'b0;
    arr_rd_ready = 1'b1; arr_wr_ready = 1'b1;
    arr_rd_rsp <= '0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
`ifdef TAG_CTRL_INIT_EN
        sram[s][w] <= {1'b1, TAG_W'($urandom_range(0, 7))};
`else
        sram[s][w] <= '0;
`endif
        ref_vld[s][w] = 1'b0;
        ref_tag[s][w] = '0;
      end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
`ifdef TAG_CTRL_INIT_EN
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("mid_init_set", arr_wr_set, 4);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
`endif
    wait_init("init");

    do_lookup(3, 24'h123456, d_hit, d_way, d_vic);
    check("A_hit", d_hit, 0); check("A_way", d_way, 0); check("A_vic", d_vic, 4'b0001);

    do_update(2, 4'b0100, 24'h00ABCD, 1'b1);
    do_lookup(2, 24'h00ABCD, d_hit, d_way, d_vic);
    check("B_hit", d_hit, 1); check("B_way", d_way, 4'b0100); check("B_vic", d_vic, 0);

    for (int w = 0; w < WAYS; w++) do_update(5, WAYS'(1) << w, 24'h500000 + w, 1'b1);
    for (int i = 0; i < 5; i++) begin
      do_lookup(5, 24'h5F0000 + i, d_hit, d_way, d_vic);
      check("C_miss_hit", d_hit, 0);
      check("C_rr_vic", d_vic, vic_tab[i]);
    end
    do_lookup(5, 24'h500002, d_hit, d_way, d_vic);
    check("C_hit_way", d_way, 4'b0100);

    do_update(5, 4'b0010, 24'h000000, 1'b0);
    do_lookup(5, 24'h777777, d_hit, d_way, d_vic);
    check("D_inv_vic", d_vic, 4'b0010);
    do_update(5, 4'b0010, 24'h500001, 1'b1);
    do_lookup(5, 24'h777777, d_hit, d_way, d_vic);
    check("D_rr_kept", d_vic, 4'b0010);

    upd_valid = 1'b1; upd_set = 0; upd_way_en = '0; upd_tag = '0; upd_vld = 1'b0;
    lk_valid = 1'b1; lk_set = 7; lk_tag = 24'h000042;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("E_upd_grant", upd_ready, (i % 5) != 4);
      check("E_lk_grant", lk_ready, (i % 5) == 4);
    end
    @(posedge clk); #1;
    upd_valid = 1'b0; lk_valid = 1'b0;
    @(posedge clk); #1;

    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        lk_valid = 1'b1; upd_valid = 1'b0; arr_rd_ready = 1'b1; lk_set = 1; lk_tag = 24'h3;
        @(posedge clk); #1;
        rst = 1'b1; lk_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
      end
      lk_valid     = ($urandom_range(0, 1) == 1);
      lk_set       = SET_W'($urandom_range(0, 3));
      lk_tag       = TAG_W'($urandom_range(0, 5));
      upd_valid    = ($urandom_range(0, 9) < 4);
      upd_set      = SET_W'($urandom_range(0, 3));
      upd_way_en   = WAYS'($urandom_range(0, 15));
      upd_tag      = TAG_W'($urandom_range(0, 5));
      upd_vld      = ($urandom_range(0, 3) != 0);
      arr_rd_ready = ($urandom_range(0, 9) < 8);
      arr_wr_ready = ($urandom_range(0, 9) < 8);
      @(posedge clk); #1;
    end
    lk_valid = 1'b0; upd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
